logic_unit_arbiter: RTL

- Shares one 32-bit bitwise logic unit (AND / OR / XOR / NOR) between two requesters, e.g. the execute stage and the Wordle letter-match engine.
- Arbitrates round-robin and accepts one operation per cycle through a valid/ready handshake.
- Computes the result and holds it in a single registered response slot until the consumer accepts it.

---
 rtl/logic_unit_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Round-robin sharing of one bitwise logic unit between two
//            requesters, with a single registered response slot.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_opcode,
    input  logic [DATA_WIDTH-1:0] req0_operandA,
    input  logic [DATA_WIDTH-1:0] req0_operandB,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_opcode,
    input  logic [DATA_WIDTH-1:0] req1_operandA,
    input  logic [DATA_WIDTH-1:0] req1_operandB,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_id,
    output logic                  rsp_isZero
);

    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(2);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_grant;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  slot_free;
    logic                  transfer;
    logic [OP_WIDTH-1:0]   sel_opcode;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] result_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        slot_free   = 1'b0;
        transfer    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        state_next  = state;

        // A tie goes to whoever did not win the last transfer.
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
        end else if (req0_valid || req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = req1_valid;
        end

        slot_free  = (state == EMPTY) || (rsp_valid && rsp_ready);
        req0_ready = reset && slot_free && grant_valid && (grant_id == 1'b0);
        req1_ready = reset && slot_free && grant_valid && (grant_id == 1'b1);
        transfer   = req0_ready || req1_ready;

        if (transfer) begin
            state_next = FULL;
        end else if (state == FULL && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        sel_opcode  = grant_id ? req1_opcode   : req0_opcode;
        sel_a       = grant_id ? req1_operandA : req0_operandA;
        sel_b       = grant_id ? req1_operandB : req0_operandB;
        result_next = ~(sel_a | sel_b);
        case (sel_opcode)
            OP_AND:  result_next = sel_a & sel_b;
            OP_OR:   result_next = sel_a | sel_b;
            OP_XOR:  result_next = sel_a ^ sel_b;
            default: result_next = ~(sel_a | sel_b);
        endcase
    end

    // Payload is only sampled on the transfer edge; otherwise the slot holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rsp_isZero <= 1'b1;
            last_grant <= 1'b1;
        end else if (transfer) begin
            rsp_result <= result_next;
            rsp_id     <= grant_id;
            rsp_isZero <= (result_next == '0);
            last_grant <= grant_id;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule
`default_nettype wire
